// File: rtl/led_req_arb.sv
// Round-robin arbiter that merges requester LED mode codes into a shared shadow
// register and feeds it to the LED pattern controller with enforced update spacing.
module led_req_arb #(
    parameter int NREQ    = 3,
    parameter int GAP_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [8*NREQ-1:0]    req_mask,
    input  logic                 lock,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          led_din,
    output logic                 led_vld,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {INIT, GAP, IDLE, ISSUE} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       ptr_reg, ptr_next;
    logic [IW-1:0]       win_reg, win_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [31:0]         shadow_reg, shadow_next;

    logic [NREQ-1:0][31:0] data_arr;
    logic [NREQ-1:0][31:0] mexp_arr;
    logic [NREQ-1:0][7:0]  mask_arr;
    logic [NREQ-1:0]       elig;
    logic                  win_found;
    logic [IW-1:0]         win_idx;
    int                    cand;
    logic [31:0]           sel_data;
    logic [31:0]           sel_mexp;
    logic [7:0]            sel_mask;
    logic [31:0]           merged;

    // Split the flat requester buses and widen each mask bit to a full nibble.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi] = req_data[32*gi +: 32];
            assign mask_arr[gi] = req_mask[8*gi +: 8];
            for (genvar gj = 0; gj < 8; gj++) begin : g_nib
                assign mexp_arr[gi][4*gj +: 4] = {4{req_mask[8*gi + gj]}};
            end
        end
    endgenerate

    assign elig = lock ? {{(NREQ-1){1'b0}}, req[0]} : req;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (elig[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    assign sel_data = data_arr[win_reg];
    assign sel_mexp = mexp_arr[win_reg];
    assign sel_mask = mask_arr[win_reg];
    assign merged   = (shadow_reg & ~sel_mexp) | (sel_data & sel_mexp);

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        win_next    = win_reg;
        cnt_next    = cnt_reg;
        shadow_next = shadow_reg;
        gnt         = '0;
        led_vld     = 1'b0;
        led_din     = shadow_reg;
        busy        = (state_reg != IDLE);

        case (state_reg)
            INIT: begin
                led_vld    = 1'b1;
                state_next = GAP;
                cnt_next   = CW'(1);
            end
            GAP: begin
                if (cnt_reg >= CW'(GAP_CYC - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (win_found) begin
                    win_next   = win_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                gnt      = NREQ'(1) << win_reg;
                ptr_next = (win_reg == IW'(NREQ - 1)) ? '0 : win_reg + 1'b1;
                // An all-zero mask is a no-op update: grant, but skip the strobe and gap.
                if (sel_mask != 8'h00) begin
                    shadow_next = merged;
                    led_din     = merged;
                    led_vld     = 1'b1;
                    state_next  = GAP;
                    cnt_next    = CW'(1);
                end else begin
                    state_next  = IDLE;
                end
            end
            default: state_next = INIT;
        endcase

        // A reset cycle suppresses any grant or strobe that would have issued.
        if (rst) begin
            gnt     = '0;
            led_vld = 1'b0;
            led_din = shadow_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= INIT;
            ptr_reg    <= '0;
            win_reg    <= '0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            win_reg    <= win_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
        end
    end

endmodule
